vec_magnitude_seq: RTL and testbench

VEC_MAGNITUDE_SEQ -- requirements
Module: vec_magnitude_seq

---
 rtl/vec_magnitude_seq_if.sv | 56 +++++
 rtl/vec_magnitude_seq.sv | 204 ++++++++++++++++++++
 tb/tb_vec_magnitude_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_magnitude_seq_if.sv
// ---------------------------------------------------------------------------
// vec_magnitude_seq_if
//   Request/response bundle for the sequential vector-magnitude engine.
//
//   Signals
//     ena     clock enable; when low the engine holds all state
//     start   request strobe, sampled on the rising clock edge
//     mode    0 = floor(sqrt(x^2 + y^2)), 1 = x^2 + y^2
//     x_in    operand x, unsigned, W bits
//     y_in    operand y, unsigned, W bits
//     result  registered result, 2W+1 bits
//     busy    high while a computation is in progress
//     valid   pulse marking a freshly loaded result
//
//   Modports
//     master  requester side (drives ena/start/mode/operands)
//     slave   engine side (drives result/busy/valid)
// ---------------------------------------------------------------------------
interface vec_magnitude_seq_if #(
  parameter int W = 8
);

  localparam int RW = W + W + 1;

  logic          ena;
  logic          start;
  logic          mode;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [RW-1:0] result;
  logic          busy;
  logic          valid;

  modport master (
    output ena,
    output start,
    output mode,
    output x_in,
    output y_in,
    input  result,
    input  busy,
    input  valid
  );

  modport slave (
    input  ena,
    input  start,
    input  mode,
    input  x_in,
    input  y_in,
    output result,
    output busy,
    output valid
  );

endinterface

// File: rtl/vec_magnitude_seq.sv
// ---------------------------------------------------------------------------
// vec_magnitude_seq
//   Multiplier-free engine that computes either x^2 + y^2 or
//   floor(sqrt(x^2 + y^2)) for two unsigned W-bit operands.
//
//   Operation
//     IDLE : wait for start (with ena); latch operands and mode.
//     SQX  : x^2 by shift-add, one multiplier bit per enabled cycle (W cycles).
//     SQY  : y^2 the same way, summed into the accumulator (W cycles).
//     ROOT : restoring digit-by-digit square root, one root bit per enabled
//            cycle, MSB first (W+1 cycles).  Skipped when mode = 1.
//     DONE : two enabled cycles; the first loads result and raises valid,
//            the second drops valid and returns to IDLE.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; aborts any computation
//     bus    vec_magnitude_seq_if.slave (ena, start, mode, x_in, y_in in;
//            result, busy, valid out)
//
//   Latency from accepting edge to the edge raising valid, in enabled edges:
//     mode 0 : 3W+2      mode 1 : 2W+1
//   Legal W range is 2..16.
// ---------------------------------------------------------------------------
module vec_magnitude_seq #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  vec_magnitude_seq_if.slave bus
);

  // Result / accumulator width (2W+1) and shared adder width (2W+2).
  localparam int RW = W + W + 1;
  localparam int AW = W + W + 2;
  // Counter must reach W (the last ROOT step).
  localparam int CW = $clog2(W + 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQX  = 3'd1,
    SQY  = 3'd2,
    ROOT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  // Shifted multiplicand during SQX/SQY; radicand shift register in ROOT.
  logic [AW-1:0]   sh_reg;
  // Multiplier bits, consumed LSB first.
  logic [W-1:0]    mr_reg;
  logic [W-1:0]    y_reg;
  logic            mode_reg;
  logic [RW-1:0]   acc_reg;
  // Partial remainder and partial root of the square-root recurrence.
  logic [AW-1:0]   rem_reg;
  logic [W:0]      root_reg;
  logic [RW-1:0]   result_reg;
  logic            valid_reg;
  logic            busy_reg;

  // The single shared adder/subtractor.
  logic [AW-1:0]   add_a;
  logic [AW-1:0]   add_b;
  logic            add_sub;
  logic [AW-1:0]   add_res;

  logic [AW-1:0]   root_cur;
  logic [AW-1:0]   root_trial;
  logic            last_sq;
  logic            last_root;

  // Bring down the next two radicand bits next to the running remainder.
  assign root_cur   = {rem_reg[AW-3:0], sh_reg[AW-1:AW-2]};
  // Trial subtrahend is 4*root + 1.
  assign root_trial = {{(AW-W-3){1'b0}}, root_reg, 2'b01};

  assign last_sq   = (cnt_reg == CW'(W - 1));
  assign last_root = (cnt_reg == CW'(W));

  // Operand selection: accumulate the shifted multiplicand while squaring,
  // trial-subtract while extracting the root.
  always_comb begin
    add_a   = {1'b0, acc_reg};
    add_b   = mr_reg[0] ? sh_reg : '0;
    add_sub = 1'b0;
    if (state_reg == ROOT) begin
      add_a   = root_cur;
      add_b   = root_trial;
      add_sub = 1'b1;
    end
  end

  assign add_res = add_sub ? (add_a - add_b) : (add_a + add_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sh_reg     <= '0;
      mr_reg     <= '0;
      y_reg      <= '0;
      mode_reg   <= 1'b0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      root_reg   <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else if (bus.ena) begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= SQX;
            sh_reg    <= AW'(bus.x_in);
            mr_reg    <= bus.x_in;
            y_reg     <= bus.y_in;
            mode_reg  <= bus.mode;
            acc_reg   <= '0;
            rem_reg   <= '0;
            root_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end

        SQX: begin
          // When the multiplier bit is 0 the adder passes acc through.
          acc_reg <= add_res[RW-1:0];
          mr_reg  <= mr_reg >> 1;
          sh_reg  <= sh_reg << 1;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_sq) begin
            state_reg <= SQY;
            sh_reg    <= AW'(y_reg);
            mr_reg    <= y_reg;
            cnt_reg   <= '0;
          end
        end

        SQY: begin
          acc_reg <= add_res[RW-1:0];
          mr_reg  <= mr_reg >> 1;
          sh_reg  <= sh_reg << 1;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_sq) begin
            cnt_reg <= '0;
            if (mode_reg) begin
              state_reg <= DONE;
            end else begin
              state_reg <= ROOT;
              // Final sum becomes the radicand; its top bit is always zero
              // because 2*(2^W-1)^2 fits in 2W+1 bits.
              sh_reg    <= add_res;
              rem_reg   <= '0;
              root_reg  <= '0;
            end
          end
        end

        ROOT: begin
          sh_reg  <= sh_reg << 2;
          cnt_reg <= cnt_reg + CW'(1);
          // Sign bit of the difference decides restore (negative) or keep.
          if (add_res[AW-1]) begin
            rem_reg  <= root_cur;
            root_reg <= {root_reg[W-1:0], 1'b0};
          end else begin
            rem_reg  <= add_res;
            root_reg <= {root_reg[W-1:0], 1'b1};
          end
          if (last_root) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
          end
        end

        DONE: begin
          // valid_reg doubles as the phase marker inside DONE.
          if (!valid_reg) begin
            valid_reg  <= 1'b1;
            result_reg <= mode_reg ? acc_reg : {{W{1'b0}}, root_reg};
          end else begin
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.busy   = busy_reg;
  assign bus.valid  = valid_reg;

endmodule

// File: tb/tb_vec_magnitude_seq.sv
// ---------------------------------------------------------------------------
// tb_vec_magnitude_seq
//   Self-checking bench for vec_magnitude_seq (W = 8).  Expected results come
//   from plain integer arithmetic (sum of squares, search for the largest
//   r with r*r <= s) and from the stated latencies.
// ---------------------------------------------------------------------------
module tb_vec_magnitude_seq;

  localparam int W = 8;
  typedef logic [2*W:0] res_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  vec_magnitude_seq_if #(.W(W)) bus ();

  vec_magnitude_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic res_t ref_result(input int unsigned x, input int unsigned y,
                                      input logic m);
    longint unsigned xx, yy, s, r;
    xx = x;
    yy = y;
    s  = xx * xx + yy * yy;
    if (m) return res_t'(s);
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return res_t'(r);
  endfunction

  function automatic int exp_lat(input logic m);
    return m ? (2 * W + 1) : (3 * W + 2);
  endfunction

  // Runs one request starting at the next edge.  ena is dropped for edges
  // stall_at+1 .. stall_at+stall_len after the accepting edge.  Operands are
  // scrambled after acceptance.  flags_ok records busy high / result stable
  // during the run and a single-cycle valid followed by idle.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input int stall_at, input int stall_len,
                        output int lat, output res_t res, output logic flags_ok);
    res_t prev_res;
    flags_ok   = 1'b1;
    prev_res   = bus.result;
    bus.ena    = 1'b1;
    bus.start  = 1'b1;
    bus.x_in   = x;
    bus.y_in   = y;
    bus.mode   = m;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.x_in   = W'($urandom);
    bus.y_in   = W'($urandom);
    bus.mode   = 1'($urandom_range(0, 1));
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      bus.ena = (n > stall_at && n <= stall_at + stall_len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (bus.valid === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.busy !== 1'b1 || bus.result !== prev_res) flags_ok = 1'b0;
    end
    res = bus.result;
    bus.ena = 1'b1;
    @(posedge clk); #1;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) flags_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.x_in  = 8'd7;
    bus.y_in  = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%b want=0", bus.valid);
    end
    n_cmp++;
    if (bus.result !== res_t'(0)) begin
      n_bad++; $display("FAIL reset_result got=%0d want=0", bus.result);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: outputs cleared while rst_n low");
  endtask

  task automatic test_pythagorean();
    int lat; res_t res; logic ok;
    run_op(8'd3, 8'd4, 1'b0, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(5)) begin
      n_bad++; $display("FAIL pyth_result got=%0d want=5", res);
    end
    n_cmp++;
    if (lat != 26) begin
      n_bad++; $display("FAIL pyth_latency got=%0d want=26", lat);
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL pyth_busy_hold got=%b want=1", ok);
    end
    $display("test_pythagorean: x=3 y=4 mode=0 result=%0d latency=%0d", res, lat);
  endtask

  task automatic test_full_scale();
    int lat; res_t res; logic ok;
    run_op(8'd255, 8'd255, 1'b0, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(360) || lat != 26 || ok !== 1'b1) begin
      n_bad++; $display("FAIL full_root got=%0d lat=%0d ok=%b want=360 lat=26 ok=1", res, lat, ok);
    end
    $display("test_full_scale: x=255 y=255 mode=0 result=%0d latency=%0d", res, lat);
    run_op(8'd255, 8'd255, 1'b1, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(130050) || lat != 17 || ok !== 1'b1) begin
      n_bad++; $display("FAIL full_sumsq got=%0d lat=%0d ok=%b want=130050 lat=17 ok=1", res, lat, ok);
    end
    $display("test_full_scale: x=255 y=255 mode=1 result=%0d latency=%0d", res, lat);
  endtask

  task automatic test_zero_nonsquare();
    int lat; res_t res; logic ok;
    run_op(8'd0, 8'd0, 1'b0, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(0) || lat != 26) begin
      n_bad++; $display("FAIL zero_root got=%0d lat=%0d want=0 lat=26", res, lat);
    end
    $display("test_zero_nonsquare: x=0 y=0 result=%0d", res);
    run_op(8'd1, 8'd1, 1'b0, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(1) || lat != 26) begin
      n_bad++; $display("FAIL floor_root got=%0d lat=%0d want=1 lat=26", res, lat);
    end
    $display("test_zero_nonsquare: x=1 y=1 result=%0d", res);
  endtask

  task automatic test_random();
    int lat; res_t res; logic ok;
    logic [W-1:0] x, y; logic m;
    int s_at, s_len, want_lat;
    res_t want;
    for (int i = 0; i < 24; i++) begin
      x        = W'($urandom);
      y        = W'($urandom);
      m        = 1'($urandom_range(0, 1));
      s_len    = (i % 3 == 0) ? 0 : int'($urandom_range(1, 3));
      s_at     = int'($urandom_range(0, exp_lat(m) - 1));
      want     = ref_result(x, y, m);
      want_lat = exp_lat(m) + s_len;
      run_op(x, y, m, s_at, s_len, lat, res, ok);
      n_cmp++;
      if (res !== want || lat != want_lat || ok !== 1'b1) begin
        n_bad++;
        $display("FAIL random_op x=%0d y=%0d m=%0d got=%0d lat=%0d ok=%b want=%0d lat=%0d ok=1",
                 x, y, m, res, lat, ok, want, want_lat);
      end
      $display("test_random: x=%0d y=%0d mode=%0d stall=%0d result=%0d latency=%0d",
               x, y, m, s_len, res, lat);
    end
  endtask

  task automatic test_stall();
    int lat; res_t res; logic ok;
    // Edges 11..15 after acceptance fall inside SQY.
    run_op(8'd6, 8'd8, 1'b0, 10, 5, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(10) || lat != 31 || ok !== 1'b1) begin
      n_bad++; $display("FAIL stall_sqy got=%0d lat=%0d ok=%b want=10 lat=31 ok=1", res, lat, ok);
    end
    $display("test_stall: x=6 y=8 mode=0 result=%0d latency=%0d", res, lat);
  endtask

  task automatic test_done_stall();
    logic [W-1:0] x, y;
    int waited;
    x = W'($urandom);
    y = W'($urandom);
    bus.ena   = 1'b1;
    bus.start = 1'b1;
    bus.x_in  = x;
    bus.y_in  = y;
    bus.mode  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waited = 0;
    while (bus.valid !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.result !== ref_result(x, y, 1'b1)) begin
      n_bad++; $display("FAIL done_stall_result got=%0d valid=%b want=%0d valid=1",
                        bus.result, bus.valid, ref_result(x, y, 1'b1));
    end
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.valid !== 1'b1) begin
        n_bad++; $display("FAIL done_stall_hold cycle=%0d got=%b want=1", i, bus.valid);
      end
    end
    bus.ena = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL done_stall_exit valid=%b busy=%b want valid=0 busy=0", bus.valid, bus.busy);
    end
    $display("test_done_stall: x=%0d y=%0d result=%0d valid held through stall", x, y, bus.result);
  endtask

  // start held high every cycle with fresh operands: each request is accepted
  // on its first edge, valid follows after the mode's latency, the edge that
  // leaves DONE ignores start and the next edge accepts again.
  task automatic test_busy_guard();
    int acc_edge, exp_edge, seen, expected_cnt;
    logic in_prog;
    logic [W-1:0] ax, ay;
    logic am;
    acc_edge = 0; exp_edge = -1; seen = 0; expected_cnt = 0;
    in_prog = 1'b0; ax = '0; ay = '0; am = 1'b0;
    bus.ena = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (k < 150) begin
        bus.start = 1'b1;
        bus.x_in  = W'($urandom);
        bus.y_in  = W'($urandom);
        bus.mode  = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
      if (!in_prog && k == acc_edge && k < 150) begin
        ax = bus.x_in; ay = bus.y_in; am = bus.mode;
        in_prog = 1'b1;
        expected_cnt++;
        exp_edge = k + exp_lat(am);
      end
      @(posedge clk); #1;
      if (bus.valid === 1'b1) begin
        n_cmp++;
        if (!(in_prog && k == exp_edge) || bus.result !== ref_result(ax, ay, am)) begin
          n_bad++;
          $display("FAIL busy_guard_pulse edge=%0d result=%0d want edge=%0d result=%0d",
                   k, bus.result, exp_edge, ref_result(ax, ay, am));
        end
        $display("test_busy_guard: edge=%0d x=%0d y=%0d mode=%0d result=%0d", k, ax, ay, am, bus.result);
        in_prog  = 1'b0;
        acc_edge = k + 2;
        seen++;
      end else if (in_prog && k == exp_edge) begin
        n_cmp++;
        n_bad++;
        $display("FAIL busy_guard_missing edge=%0d valid=%b want valid=1", k, bus.valid);
        in_prog = 1'b0;
      end
      if (k >= 150 && !in_prog) break;
    end
    n_cmp++;
    if (seen != expected_cnt || seen < 3) begin
      n_bad++; $display("FAIL busy_guard_count got=%0d want=%0d", seen, expected_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int vseen, lat;
    res_t res; logic ok;
    bus.ena   = 1'b1;
    bus.start = 1'b1;
    bus.x_in  = 8'd200;
    bus.y_in  = 8'd100;
    bus.mode  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // ROOT spans edges 2W+1 .. 3W+1 after acceptance.
    repeat (2 * W + 3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== res_t'(0)) begin
      n_bad++; $display("FAIL abort_clear busy=%b valid=%b result=%0d want 0/0/0",
                        bus.busy, bus.valid, bus.result);
    end
    vseen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.valid !== 1'b0) vseen++;
    end
    n_cmp++;
    if (vseen != 0) begin
      n_bad++; $display("FAIL abort_no_valid got=%0d pulses want=0", vseen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd5, 8'd12, 1'b0, 1000, 0, lat, res, ok);
    n_cmp++;
    if (res !== res_t'(13) || lat != 26 || ok !== 1'b1) begin
      n_bad++; $display("FAIL abort_restart got=%0d lat=%0d ok=%b want=13 lat=26 ok=1", res, lat, ok);
    end
    $display("test_reset_abort: after abort x=5 y=12 result=%0d latency=%0d", res, lat);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pythagorean();
    test_full_scale();
    test_zero_nonsquare();
    test_random();
    test_stall();
    test_done_stall();
    test_busy_guard();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
